// File: rtl/flop_pkg.sv
// Shared constants for the latch/flip-flop library: forced values of the
// asynchronous overrides.
package flop_pkg;

  localparam int unsigned FLOP_W = 1;

  localparam logic [FLOP_W-1:0] Q_RESET_VAL = 1'b0;
  localparam logic [FLOP_W-1:0] Q_SET_VAL   = 1'b1;

endpackage : flop_pkg

// File: rtl/dflop.sv
// Rising-edge D flip-flop with complementary outputs and asynchronous
// active-low clear (highest priority) and preset.
module dflop
  import flop_pkg::*;
(
  output logic q,
  output logic qbar,
  input  logic d,
  input  logic set,
  input  logic reset,
  input  logic clk
);

  // Clear dominates preset, so both low still yields a valid q=0/qbar=1.
  always_ff @(posedge clk or negedge reset or negedge set) begin
    if (!reset) begin
      q <= Q_RESET_VAL;
    end else if (!set) begin
      q <= Q_SET_VAL;
    end else begin
      q <= d;
    end
  end

  assign qbar = ~q;

endmodule : dflop

// File: tb/tb_dflop.sv
// Directed bench for dflop: stimulus queues hand-computed expectations,
// a monitor process pops and compares them against q/qbar.
module tb_dflop;

  logic clk;
  logic reset;
  logic set;
  logic d;
  logic q;
  logic qbar;

  int vectors     = 0;
  int miscompares = 0;
  bit inv_armed   = 1'b0;

  typedef struct {
    string name;
    logic  exp_q;
  } exp_t;

  exp_t exp_q_fifo[$];
  event sample_ev;

  dflop dut (
    .q     (q),
    .qbar  (qbar),
    .d     (d),
    .set   (set),
    .reset (reset),
    .clk   (clk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_until(input int t);
    if (int'($time) < t) #(t - int'($time));
  endtask

  task automatic expect_at(input int t, input string name, input logic exp_q);
    exp_t e;
    wait_until(t);
    e.name  = name;
    e.exp_q = exp_q;
    exp_q_fifo.push_back(e);
    -> sample_ev;
  endtask

  // Monitor: pops every pending expectation when a sample point is signalled.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      while (exp_q_fifo.size() > 0) begin
        e = exp_q_fifo.pop_front();
        vectors++;
        if (q !== e.exp_q || qbar !== ~e.exp_q) begin
          miscompares++;
          $display("FAIL %s @%0t: q=%b qbar=%b, required q=%b qbar=%b",
                   e.name, $time, q, qbar, e.exp_q, ~e.exp_q);
        end
      end
    end
  end

  // Complement invariant, sampled mid-way between rising edges.
  always @(negedge clk) begin
    if (inv_armed) begin
      vectors++;
      if (qbar !== ~q) begin
        miscompares++;
        $display("FAIL qbar_invariant @%0t: q=%b qbar=%b, required qbar=~q",
                 $time, q, qbar);
      end
    end
  end

  initial begin
    #10000;
    $display("FAIL watchdog @%0t: bench did not complete, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    set   = 1'b1;
    d     = 1'b0;

    // Clock capture
    wait_until(2);  d = 1'b1;
    expect_at(6,  "capture_d1_edge5", 1'b1);
    inv_armed = 1'b1;
    wait_until(7);  d = 1'b0;
    expect_at(16, "capture_d0_edge15", 1'b0);
    wait_until(18); d = 1'b1;
    expect_at(21, "falling_edge_ignored", 1'b0);
    wait_until(22); d = 1'b1;
    expect_at(26, "capture_d1_edge25", 1'b1);
    expect_at(36, "hold_d1_edge35", 1'b1);

    // Async reset mid-cycle, clock ignored while held
    wait_until(47); reset = 1'b0;
    expect_at(48, "async_reset_immediate", 1'b0);
    wait_until(52); d = 1'b1;
    expect_at(56, "reset_held_edge55", 1'b0);
    wait_until(62); d = 1'b0;
    wait_until(72); d = 1'b1;
    expect_at(76, "reset_held_edge75", 1'b0);

    // Async set as reset releases
    wait_until(82); reset = 1'b1; set = 1'b0; d = 1'b0;
    expect_at(83, "async_set_immediate", 1'b1);
    expect_at(86, "set_held_edge85", 1'b1);
    expect_at(96, "set_held_edge95", 1'b1);

    // Both overrides low: reset priority
    wait_until(100); d = 1'b1; reset = 1'b0;
    expect_at(101, "both_low_reset_wins", 1'b0);
    expect_at(106, "both_low_edge105", 1'b0);
    wait_until(108); set = 1'b1;
    expect_at(109, "set_released_reset_low", 1'b0);

    // Reset release between edges holds until next rising edge
    wait_until(112); reset = 1'b1; d = 1'b1;
    expect_at(113, "release_holds_forced", 1'b0);
    expect_at(116, "release_capture_edge115", 1'b1);
    wait_until(117); d = 1'b0;
    expect_at(126, "capture_d0_edge125", 1'b0);

    // Set from q=0 mid-cycle, then release and resume capture
    wait_until(128); set = 1'b0;
    expect_at(129, "async_set_from_q0", 1'b1);
    wait_until(132); set = 1'b1; d = 1'b0;
    expect_at(133, "set_release_holds", 1'b1);
    expect_at(136, "set_release_capture_edge135", 1'b0);

    wait_until(140);
    inv_armed = 1'b0;
    if (exp_q_fifo.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d pending, required 0", exp_q_fifo.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_dflop
